e203_itcm_icb_slv: RTL and testbench

- ICB responder (slave) for the ITCM. It terminates the IFU/LSU-side ICB command/response channel and drives a single-port 64-bit SRAM with 1-cycle read latency.
- It generates the holdup indication that tells the fetch initiator the SRAM output still holds the last-read line.
- It sits between the ITCM ICB arbiter and the ITCM RAM macro wrapper.

---
 rtl/e203_itcm_icb_slv.sv | 118 +++++++++++
 tb/tb_e203_itcm_icb_slv.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/e203_itcm_icb_slv.sv
// ITCM ICB responder: terminates the ICB command/response channel and drives a 64-bit single-port SRAM.
// Optional E203_ITCM_SLV_SKID_EN adds a 1-entry skid buffer so two transactions can be outstanding.
module e203_itcm_icb_slv #(
    parameter int          AW        = 16,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          RAM_AW    = AW - 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [31:0]       icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [63:0]       icb_cmd_wdata,
    input  logic [7:0]        icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic              icb_rsp_err,
    output logic [63:0]       icb_rsp_rdata,
    output logic              itcm_holdup,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wem,
    output logic [63:0]       ram_din,
    input  logic [63:0]       ram_dout
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t      state;
    logic        stage_rd;
    logic        stage_err;
    logic        in_rgn;
    logic        cmd_hsk;
    logic        rsp_hsk;
    logic [63:0] stage_rdata;
    logic [2:0]  unused_addr_lsb;

    assign unused_addr_lsb = icb_cmd_addr[2:0];

    assign in_rgn  = (icb_cmd_addr[31:AW] == BASE_ADDR[31:AW]);
    assign cmd_hsk = icb_cmd_valid & icb_cmd_ready;
    assign rsp_hsk = icb_rsp_valid & icb_rsp_ready;

    assign ram_cs   = cmd_hsk & in_rgn;
    assign ram_we   = ~icb_cmd_read;
    assign ram_addr = icb_cmd_addr[AW-1:3];
    assign ram_wem  = icb_cmd_read ? 8'h00 : icb_cmd_wmask;
    assign ram_din  = icb_cmd_wdata;

    // ram_dout is only rewritten by a new access, so the stage can read it live.
    assign stage_rdata   = stage_rd ? ram_dout : '0;
    assign icb_rsp_valid = (state == PEND);

`ifdef E203_ITCM_SLV_SKID_EN
    logic        buf_full;
    logic [64:0] buf_q;

    assign icb_cmd_ready = rst_n & ~buf_full;
    assign icb_rsp_err   = icb_rsp_valid & (buf_full ? buf_q[64] : stage_err);
    assign icb_rsp_rdata = ~icb_rsp_valid ? '0 : (buf_full ? buf_q[63:0] : stage_rdata);

    // Buffer holds the older response; the stage only retires once the buffer is empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            stage_rd    <= 1'b0;
            stage_err   <= 1'b0;
            itcm_holdup <= 1'b0;
            buf_full    <= 1'b0;
            buf_q       <= '0;
        end else begin
            if ((state == PEND) && !icb_rsp_ready && cmd_hsk) begin
                buf_full <= 1'b1;
                buf_q    <= {stage_err, stage_rdata};
            end else if (rsp_hsk && buf_full) begin
                buf_full <= 1'b0;
            end
            if (cmd_hsk) begin
                state     <= PEND;
                stage_rd  <= icb_cmd_read & in_rgn;
                stage_err <= ~in_rgn;
            end else if (rsp_hsk && !buf_full) begin
                state <= IDLE;
            end
            if (ram_cs) begin
                itcm_holdup <= icb_cmd_read;
            end
        end
    end
`else
    assign icb_cmd_ready = rst_n & ((state == IDLE) | rsp_hsk);
    assign icb_rsp_err   = icb_rsp_valid & stage_err;
    assign icb_rsp_rdata = icb_rsp_valid ? stage_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            stage_rd    <= 1'b0;
            stage_err   <= 1'b0;
            itcm_holdup <= 1'b0;
        end else begin
            if (cmd_hsk) begin
                state     <= PEND;
                stage_rd  <= icb_cmd_read & in_rgn;
                stage_err <= ~in_rgn;
            end else if (rsp_hsk) begin
                state <= IDLE;
            end
            if (ram_cs) begin
                itcm_holdup <= icb_cmd_read;
            end
        end
    end
`endif

endmodule

// File: tb/tb_e203_itcm_icb_slv.sv
// Self-checking bench for e203_itcm_icb_slv: vector table for single accesses,
// scoreboard queue for responses, hand-written backpressure and reset sequences.
module tb_e203_itcm_icb_slv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [63:0] icb_cmd_wdata;
    logic [7:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [63:0] icb_rsp_rdata;
    logic        itcm_holdup;
    logic        ram_cs;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wem;
    logic [63:0] ram_din;
    logic [63:0] ram_dout;

    e203_itcm_icb_slv #(.AW(16), .BASE_ADDR(32'h8000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata),
        .itcm_holdup(itcm_holdup),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM stand-in: read data appears the cycle after a read select, held otherwise.
    logic [63:0] drive_dout;
    always @(posedge clk) begin
        if (ram_cs && !ram_we) ram_dout <= drive_dout;
    end

    // Scoreboard: {err, rdata} pushed on command handshake, popped on response handshake.
    logic [64:0] sb_q[$];
    logic        cur_err;
    logic [63:0] cur_rdata;

    always @(negedge clk) begin
        if (rst_n && icb_cmd_valid && icb_cmd_ready) sb_q.push_back({cur_err, cur_rdata});
    end

    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n && icb_rsp_valid && icb_rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_err", {63'd0, icb_rsp_err}, {63'd0, e[64]});
                check("rsp_rdata", icb_rsp_rdata, e[63:0]);
            end
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] dout;
        logic        cs;
        logic [12:0] waddr;
        logic [63:0] rdata;
        logic        err;
        logic        hold;
    } vec_t;

    vec_t vt[8];

    task automatic drive(input logic [31:0] a, input logic rd, input logic [63:0] wd,
                         input logic [7:0] wm, input logic [63:0] dout,
                         input logic [63:0] exp_rdata, input logic exp_err);
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = a;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        drive_dout    = dout;
        cur_rdata     = exp_rdata;
        cur_err       = exp_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              addr          rd    wdata                   wmask  dout                    cs    waddr     rdata                   err   hold
        vt[0] = '{32'h8000_0010, 1'b1, 64'h0,                  8'h00, 64'hDEAD_BEEF_0123_4567, 1'b1, 13'd2,    64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1};
        vt[1] = '{32'h8000_0008, 1'b0, 64'h1122_3344_5566_7788, 8'h0F, 64'hFFFF_0000_FFFF_0000, 1'b1, 13'd1,    64'h0,                  1'b0, 1'b0};
        vt[2] = '{32'h9000_0000, 1'b1, 64'h0,                  8'h00, 64'h0BAD_0BAD_0BAD_0BAD, 1'b0, 13'd0,    64'h0,                  1'b1, 1'b0};
        vt[3] = '{32'h8000_FFF8, 1'b1, 64'h0,                  8'h00, 64'h0123_4567_89AB_CDEF, 1'b1, 13'h1FFF, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1};
        vt[4] = '{32'h8001_0000, 1'b1, 64'h0,                  8'h00, 64'h7777_7777_7777_7777, 1'b0, 13'd0,    64'h0,                  1'b1, 1'b1};
        vt[5] = '{32'h7FFF_FFF8, 1'b0, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 64'h6666_6666_6666_6666, 1'b0, 13'd0,    64'h0,                  1'b1, 1'b1};
        vt[6] = '{32'h8000_0000, 1'b0, 64'hA0A1_A2A3_A4A5_A6A7, 8'hFF, 64'h5555_5555_5555_5555, 1'b1, 13'd0,    64'h0,                  1'b0, 1'b0};
        vt[7] = '{32'h8000_0020, 1'b1, 64'h0,                  8'h00, 64'hA5A5_5A5A_C3C3_3C3C, 1'b1, 13'd4,    64'hA5A5_5A5A_C3C3_3C3C, 1'b0, 1'b1};

        rst_n = 1'b0;
        icb_rsp_ready = 1'b1;
        ram_dout = 64'h0;
        drive(32'h8000_0010, 1'b1, 64'h0, 8'h00, 64'h1, 64'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", {63'd0, icb_cmd_ready}, 64'd0);
        check("reset_ram_cs", {63'd0, ram_cs}, 64'd0);
        check("reset_rsp_valid", {63'd0, icb_rsp_valid}, 64'd0);
        check("reset_holdup", {63'd0, itcm_holdup}, 64'd0);
        icb_cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table vectors, issued back to back.
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].addr, vt[i].rd, vt[i].wdata, vt[i].wmask, vt[i].dout, vt[i].rdata, vt[i].err);
            icb_rsp_ready = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_cmd_ready", i), {63'd0, icb_cmd_ready}, 64'd1);
            check($sformatf("v%0d_ram_cs", i), {63'd0, ram_cs}, {63'd0, vt[i].cs});
            if (vt[i].cs) begin
                check($sformatf("v%0d_ram_we", i), {63'd0, ram_we}, {63'd0, ~vt[i].rd});
                check($sformatf("v%0d_ram_addr", i), {51'd0, ram_addr}, {51'd0, vt[i].waddr});
                check($sformatf("v%0d_ram_wem", i), {56'd0, ram_wem}, {56'd0, (vt[i].rd ? 8'h00 : vt[i].wmask)});
                if (!vt[i].rd) check($sformatf("v%0d_ram_din", i), ram_din, vt[i].wdata);
            end
            @(posedge clk); #1;
            check($sformatf("v%0d_rsp_valid", i), {63'd0, icb_rsp_valid}, 64'd1);
            check($sformatf("v%0d_holdup", i), {63'd0, itcm_holdup}, {63'd0, vt[i].hold});
        end
        icb_cmd_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure: response stalls for 3 cycles while the next read waits.
        drive(32'h8000_0030, 1'b1, 64'h0, 8'h00, 64'h5555_AAAA_1234_5678, 64'h5555_AAAA_1234_5678, 1'b0);
        icb_rsp_ready = 1'b0;
        @(posedge clk); #1;
        drive(32'h8000_0038, 1'b1, 64'h0, 8'h00, 64'h9999_8888_7777_6666, 64'h9999_8888_7777_6666, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d_rsp_valid", c), {63'd0, icb_rsp_valid}, 64'd1);
            check($sformatf("bp%0d_rdata", c), icb_rsp_rdata, 64'h5555_AAAA_1234_5678);
            check($sformatf("bp%0d_cmd_ready", c), {63'd0, icb_cmd_ready}, 64'd0);
            check($sformatf("bp%0d_ram_cs", c), {63'd0, ram_cs}, 64'd0);
            @(posedge clk); #1;
        end
        icb_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_cmd_ready", {63'd0, icb_cmd_ready}, 64'd1);
        check("bp_release_ram_cs", {63'd0, ram_cs}, 64'd1);
        @(posedge clk); #1;
        icb_cmd_valid = 1'b0;
        check("bp_next_rsp_valid", {63'd0, icb_rsp_valid}, 64'd1);
        @(posedge clk); #1;
        check("bp_idle_rsp_valid", {63'd0, icb_rsp_valid}, 64'd0);

        // Reset while a response is stalled: it must be dropped.
        drive(32'h8000_0040, 1'b1, 64'h0, 8'h00, 64'h4040_4040_4040_4040, 64'h4040_4040_4040_4040, 1'b0);
        icb_rsp_ready = 1'b0;
        @(posedge clk); #1;
        icb_cmd_valid = 1'b0;
        check("mid_rsp_valid_before", {63'd0, icb_rsp_valid}, 64'd1);
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        check("mid_rsp_valid_after", {63'd0, icb_rsp_valid}, 64'd0);
        check("mid_holdup_after", {63'd0, itcm_holdup}, 64'd0);
        rst_n = 1'b1;
        icb_rsp_ready = 1'b1;
        drive(32'h8000_0048, 1'b1, 64'h0, 8'h00, 64'h4848_4848_4848_4848, 64'h4848_4848_4848_4848, 1'b0);
        @(negedge clk);
        check("post_reset_cmd_ready", {63'd0, icb_cmd_ready}, 64'd1);
        @(posedge clk); #1;
        icb_cmd_valid = 1'b0;
        check("post_reset_holdup", {63'd0, itcm_holdup}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
